// File: rtl/gb_frame_sequencer_if.sv
// Frame-sequencer bundle: APU power/DIV inputs plus the per-channel function strobes and step export.
// Strobes are single-cycle pulses with no handshake or backpressure; a channel samples them on the next posedge.
interface gb_frame_sequencer_if;
  logic       apu_enable;
  logic       div_bit;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_vol_env;
  logic [2:0] step;
  logic       length_skip;

  modport master (
    input  apu_enable, div_bit,
    output clk_length_ctr, clk_sweep, clk_vol_env, step, length_skip
  );

  modport slave (
    output apu_enable, div_bit,
    input  clk_length_ctr, clk_sweep, clk_vol_env, step, length_skip
  );
endinterface

// File: rtl/gb_frame_sequencer.sv
// APU frame sequencer: 512 Hz tick -> 8-step schedule of length/sweep/envelope strobes.
// Optional FRAME_SEQ_EXT_DIV_EN: tick from the falling edge of DIV bit instead of the internal prescaler.
module gb_frame_sequencer #(
  parameter int CLK_DIV = 8192
) (
  input  logic                 clk,
  input  logic                 reset,
  gb_frame_sequencer_if.master fs
);

  logic [2:0] step_q;
  logic       len_q;
  logic       sweep_q;
  logic       env_q;
  logic       div_q;
  logic       tick;

`ifdef FRAME_SEQ_EXT_DIV_EN
  // Falling edge of the DIV bit; ignored while the APU is powered off.
  assign tick = fs.apu_enable && div_q && !fs.div_bit;
`else
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] prescaler;
  logic          unused_div;

  assign unused_div = div_q;
  assign tick       = fs.apu_enable && (prescaler == PW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset || !fs.apu_enable) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end
`endif

  // Power-off holds the reset state; only the DIV history keeps sampling.
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q  <= 3'd0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      div_q <= fs.div_bit;
      if (!fs.apu_enable) begin
        step_q  <= 3'd0;
        len_q   <= 1'b0;
        sweep_q <= 1'b0;
        env_q   <= 1'b0;
      end else if (tick) begin
        step_q  <= step_q + 3'd1;
        len_q   <= ~step_q[0];
        sweep_q <= (step_q == 3'd2) || (step_q == 3'd6);
        env_q   <= (step_q == 3'd7);
      end else begin
        len_q   <= 1'b0;
        sweep_q <= 1'b0;
        env_q   <= 1'b0;
      end
    end
  end

  assign fs.clk_length_ctr = len_q;
  assign fs.clk_sweep      = sweep_q;
  assign fs.clk_vol_env    = env_q;
  assign fs.step           = step_q;
  assign fs.length_skip    = step_q[0];

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Directed bench for gb_frame_sequencer with CLK_DIV=8; FRAME_SEQ_EXT_DIV_EN selects the DIV-edge scenario.
module tb_gb_frame_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gb_frame_sequencer_if fs ();

  gb_frame_sequencer #(.CLK_DIV(8)) dut (
    .clk   (clk),
    .reset (reset),
    .fs    (fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    fs.apu_enable = 1'b1;
    fs.div_bit    = 1'b0;
    for (int i = 0; i < 3; i++) edge_wait();
    checks++;
    if ({fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000", {fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env});
    end
    checks++;
    if (fs.step !== 3'd0 || fs.length_skip !== 1'b0) begin
      errors++;
      $display("FAIL reset_step: step %0d skip %b want 0 0", fs.step, fs.length_skip);
    end
  endtask

`ifndef FRAME_SEQ_EXT_DIV_EN
  task automatic test_first_pulse();
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      edge_wait();
      checks++;
      if (fs.clk_length_ctr !== (i == 8) || fs.clk_sweep !== 1'b0 || fs.clk_vol_env !== 1'b0) begin
        errors++;
        $display("FAIL first_pulse edge %0d: len %b sweep %b env %b want len %b", i,
                 fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env, (i == 8));
      end
      checks++;
      if (fs.step !== ((i == 8) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL first_step edge %0d: got %0d want %0d", i, fs.step, (i == 8) ? 1 : 0);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [2:0] m_step;
    logic [2:0] s;
    logic       e_len, e_sw, e_env;
    int         n_len, n_sw, n_env;
    m_step = 3'd1;
    n_len = 0; n_sw = 0; n_env = 0;
    for (int i = 1; i <= 64; i++) begin
      edge_wait();
      e_len = 1'b0; e_sw = 1'b0; e_env = 1'b0;
      if (i % 8 == 0) begin
        s      = m_step;
        e_len  = (s == 3'd0) || (s == 3'd2) || (s == 3'd4) || (s == 3'd6);
        e_sw   = (s == 3'd2) || (s == 3'd6);
        e_env  = (s == 3'd7);
        m_step = s + 3'd1;
      end
      n_len += int'(fs.clk_length_ctr);
      n_sw  += int'(fs.clk_sweep);
      n_env += int'(fs.clk_vol_env);
      checks++;
      if ({fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env} !== {e_len, e_sw, e_env}) begin
        errors++;
        $display("FAIL frame_strobes edge %0d: got %b want %b", i,
                 {fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env}, {e_len, e_sw, e_env});
      end
      checks++;
      if (fs.step !== m_step || fs.length_skip !== m_step[0]) begin
        errors++;
        $display("FAIL frame_step edge %0d: step %0d skip %b want %0d %b", i,
                 fs.step, fs.length_skip, m_step, m_step[0]);
      end
    end
    checks++;
    if (n_len != 4 || n_sw != 2 || n_env != 1) begin
      errors++;
      $display("FAIL frame_counts: len %0d sweep %0d env %0d want 4 2 1", n_len, n_sw, n_env);
    end
  endtask

  task automatic test_power_off();
    for (int i = 0; i < 32; i++) edge_wait();
    checks++;
    if (fs.step !== 3'd5) begin
      errors++;
      $display("FAIL off_pre_step: got %0d want 5", fs.step);
    end
    fs.apu_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_wait();
      checks++;
      if (fs.step !== 3'd0 || fs.length_skip !== 1'b0 ||
          {fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env} !== 3'b000) begin
        errors++;
        $display("FAIL off_hold cycle %0d: step %0d skip %b strobes %b want 0 0 000", i,
                 fs.step, fs.length_skip, {fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env});
      end
    end
    fs.apu_enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      edge_wait();
      checks++;
      if ({fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env} !== {(i == 8), 2'b00}) begin
        errors++;
        $display("FAIL reenable edge %0d: got %b want %b", i,
                 {fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env}, {(i == 8), 2'b00});
      end
    end
  endtask

  task automatic test_off_at_tick();
    for (int i = 0; i < 55; i++) edge_wait();
    checks++;
    if (fs.step !== 3'd7) begin
      errors++;
      $display("FAIL tick_pre_step: got %0d want 7", fs.step);
    end
    fs.apu_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      checks++;
      if (fs.clk_vol_env !== 1'b0 || fs.clk_length_ctr !== 1'b0 || fs.step !== 3'd0) begin
        errors++;
        $display("FAIL off_at_tick cycle %0d: env %b len %b step %0d want 0 0 0", i,
                 fs.clk_vol_env, fs.clk_length_ctr, fs.step);
      end
    end
    fs.apu_enable = 1'b1;
  endtask

  task automatic test_reset_mid_strobe();
    for (int i = 0; i < 24; i++) edge_wait();
    checks++;
    if (fs.clk_sweep !== 1'b1 || fs.step !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_sweep: sweep %b step %0d want 1 3", fs.clk_sweep, fs.step);
    end
    reset = 1'b0;
    edge_wait();
    checks++;
    if (fs.clk_sweep !== 1'b0 || fs.clk_length_ctr !== 1'b0 || fs.step !== 3'd0 || fs.length_skip !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_strobe: sweep %b len %b step %0d skip %b want 0 0 0 0",
               fs.clk_sweep, fs.clk_length_ctr, fs.step, fs.length_skip);
    end
    reset = 1'b1;
  endtask
`else
  task automatic test_ext_div();
    logic [2:0] m_step;
    logic [2:0] s;
    logic       e_len, e_sw, e_env;
    m_step = 3'd0;
    reset  = 1'b1;
    for (int p = 0; p < 9; p++) begin
      for (int i = 0; i < 10; i++) begin
        fs.div_bit = (i < 5);
        edge_wait();
        e_len = 1'b0; e_sw = 1'b0; e_env = 1'b0;
        if (i == 5) begin
          s      = m_step;
          e_len  = ~s[0];
          e_sw   = (s == 3'd2) || (s == 3'd6);
          e_env  = (s == 3'd7);
          m_step = s + 3'd1;
        end
        checks++;
        if ({fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env} !== {e_len, e_sw, e_env} ||
            fs.step !== m_step || fs.length_skip !== m_step[0]) begin
          errors++;
          $display("FAIL ext_div p%0d i%0d: strobes %b step %0d skip %b want %b %0d %b", p, i,
                   {fs.clk_length_ctr, fs.clk_sweep, fs.clk_vol_env}, fs.step, fs.length_skip,
                   {e_len, e_sw, e_env}, m_step, m_step[0]);
        end
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifndef FRAME_SEQ_EXT_DIV_EN
    test_first_pulse();
    test_full_frame();
    test_power_off();
    test_off_at_tick();
    test_reset_mid_strobe();
`else
    test_ext_div();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
